// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Button conditioning and mode control for the stopwatch. Three raw push
//   buttons are synchronised and debounced. The press events drive a small
//   FSM that gates the BCD digit counter, issues counter clears and holds a
//   lap snapshot. The FSM also selects live or lap digits for the 7-segment
//   driver.
//
// Ports
//   clk_100MHz  in   system clock (only clock)
//   reset       in   synchronous, active-low reset
//   btn_ss      in   raw start/stop button, async, active-high
//   btn_lap     in   raw lap button, async, active-high
//   btn_clr     in   raw clear button, async, active-high
//   live_bcd    in   live digits {hundreds,tens,ones,tenths}
//   count_en    out  digit counter advances on 10 Hz ticks
//   count_clr   out  one-cycle clear of 10 Hz generator and digit counter
//   disp_bcd    out  digits to the 7-segment driver (live or lap)
//   lap_active  out  display frozen on lap snapshot
//   state       out  FSM state for debug/LED
//
// state | meaning
// IDLE  | stopped and cleared, waiting for start
// RUN   | counting, display shows live digits
// PAUSE | counting halted, digits held, clear allowed
// LAP   | counting, display frozen on lap snapshot

module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic [15:0] live_bcd,
    output logic        count_en,
    output logic        count_clr,
    output logic [15:0] disp_bcd,
    output logic        lap_active,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int unsigned B_SS  = 0;
    localparam int unsigned B_CLR = 1;
    localparam int unsigned B_LAP = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic [2:0]       press_q;
    logic [2:0]       press_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_t      state_q;
    logic        count_en_q;
    logic        count_clr_q;
    logic        lap_active_q;
    logic [15:0] lap_q;

    logic ev_ss;
    logic ev_clr;
    logic ev_lap;

    assign btn_raw = {btn_lap, btn_clr, btn_ss};

    // The counter runs only while the synchronised level disagrees with the
    // accepted level. Any agreeing cycle restarts it, so glitches shorter
    // than DEBOUNCE_CYCLES never reach the stable level.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            press_d[i]  = 1'b0;
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Priority ss > clr > lap is resolved before the state decode. Only the
    // winning event reaches the FSM, even when that event is ignored in the
    // current state.
    assign ev_ss  = press_q[B_SS];
    assign ev_clr = press_q[B_CLR] & ~press_q[B_SS];
    assign ev_lap = press_q[B_LAP] & ~press_q[B_SS] & ~press_q[B_CLR];

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_en_q   <= 1'b0;
            count_clr_q  <= 1'b1;
            lap_active_q <= 1'b0;
            lap_q        <= '0;
        end else begin
            // Enable and lap select follow the state one cycle late.
            count_en_q   <= (state_q == ST_RUN) || (state_q == ST_LAP);
            lap_active_q <= (state_q == ST_LAP);
            count_clr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ev_ss) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ev_ss) begin
                        state_q <= ST_PAUSE;
                    end else if (ev_lap) begin
                        state_q <= ST_LAP;
                        lap_q   <= live_bcd;
                    end
                end
                ST_LAP: begin
                    if (ev_ss) begin
                        state_q <= ST_PAUSE;
                    end else if (ev_clr) begin
                        state_q <= ST_RUN;
                    end else if (ev_lap) begin
                        lap_q <= live_bcd;
                    end
                end
                ST_PAUSE: begin
                    if (ev_ss) begin
                        state_q <= ST_RUN;
                    end else if (ev_clr) begin
                        state_q     <= ST_IDLE;
                        count_clr_q <= 1'b1;
                        lap_q       <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign count_en   = count_en_q;
    assign count_clr  = count_clr_q;
    assign lap_active = lap_active_q;
    assign disp_bcd   = lap_active_q ? lap_q : live_bcd;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the stopwatch datapath: the 10 Hz generator, the BCD digit counter (tenths/ones/tens/hundreds) and the 7-segment driver.
- Debounces the three push buttons: start/stop, lap and clear.
- Gates counting, issues clears and captures a lap snapshot of the four BCD digits.
- Selects live or lap digits for the 7-segment driver; sits between the button pins and the counter/display path.

Parameters:
- DEBOUNCE_CYCLES, 1000000: clk_100MHz cycles a synchronized button must stay stable before its level is accepted (10 ms at 100 MHz).
- CNT_W, 20: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk_100MHz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- btn_ss  in  1  raw start/stop button, asynchronous, active-high.
- btn_lap  in  1  raw lap button, asynchronous, active-high.
- btn_clr  in  1  raw clear button, asynchronous, active-high.
- live_bcd  in  16  live digits {hundred,tens,ones,tenth}, 4 bits each.
- count_en  out  1  1 = digit counter advances on 10 Hz ticks.
- count_clr  out  1  one-cycle pulse that zeroes the 10 Hz generator and the digit counter.
- disp_bcd  out  16  digits routed to seg7 control (live or lap).
- lap_active  out  1  1 = display frozen on lap snapshot.
- state  out  2  FSM state encoding for debug/LED.

Behaviour:
- Reset (reset==0 at a clk_100MHz edge):
  - state=IDLE(2'd0), count_en=0, count_clr=1 during reset and for the first cycle after release, then 0.
  - lap_active=0, lap register=16'h0000, all synchronizers, debounce counters and stable levels = 0.
  - Reset mid-run or mid-debounce aborts everything; no button event is generated from pre-reset history.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce counter.
  - If the synchronized level != stable level, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with level still different, the stable level updates and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES resets the counter and produces no change.
  - Press event = one-cycle pulse on the stable-level 0->1 transition. Releases produce no event.
  - Latency from raw press to event: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3. count_en=1 in RUN and LAP only.
- IDLE:
  - ss -> RUN.
  - lap and clr ignored.
- RUN:
  - ss -> PAUSE.
  - lap -> LAP, capturing live_bcd into the lap register in the same cycle.
  - clr ignored (clear while running is not allowed).
- LAP (counter keeps running):
  - lap -> recapture live_bcd, stay in LAP.
  - ss -> PAUSE; the lap snapshot is discarded from the display.
  - clr -> RUN (exits lap view, no counter clear).
- PAUSE:
  - ss -> RUN.
  - clr -> IDLE, with count_clr pulsed for exactly 1 cycle and the lap register zeroed.
  - lap ignored.
- Simultaneous events in one cycle, priority ss > clr > lap:
  - Only the highest-priority event is acted on.
  - The others are dropped, not queued.
- Outputs:
  - count_en and lap_active are registered from state (1-cycle latency after the transition edge).
  - disp_bcd = lap register when lap_active else live_bcd; combinational mux on registered select.
  - lap_active=1 only in LAP.
- Arithmetic:
  - No arithmetic on BCD; the snapshot is captured as-is.
  - Debounce counter saturates logic-wise at DEBOUNCE_CYCLES-1; it never wraps.
- Held buttons generate exactly one event per press regardless of hold duration.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 for 3 cycles, release -> count_en=0, state=0, count_clr=1 until first post-release cycle then 0, disp_bcd=live_bcd.
- Debounce: btn_ss high 3 cycles then low -> no state change. btn_ss high 10 cycles -> state=RUN (1) on cycle 2+4+1 after press, count_en=1 one cycle later. Hold 1000 cycles -> no further transition.
- Lap: in RUN with live_bcd=16'h0123, press lap -> state=3, lap_active=1, disp_bcd=16'h0123 while live_bcd advances to 16'h0150. Second lap at 16'h0150 -> disp_bcd=16'h0150.
- Pause/clear: RUN -> ss -> PAUSE, count_en=0. clr -> state=IDLE, count_clr high exactly 1 cycle, lap register=0. clr in RUN -> no count_clr, state stays RUN.
- Simultaneous events: ss and clr events in the same cycle in PAUSE -> state=RUN, no count_clr. lap+clr in LAP -> state=RUN.
- Reset mid-operation: reset=0 while in LAP with btn_lap mid-debounce -> state=IDLE, lap_active=0. After release, a still-held btn_lap yields its event only after a full debounce; in IDLE it is ignored.
